// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32 core: sequences fetch/decode/execute phases
// and decodes ALUOp plus funct fields into the datapath ALU control.
module multicycle_controller #(
  parameter bit TRAP_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BEQ, S_HALT
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_pc_update;
  logic        w_branch;
  logic        w_mem_write;
  logic        w_ir_write;
  logic        w_reg_write;
  logic [1:0]  w_alu_op;

  // State register; reset parks the FSM in FETCH immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and Moore outputs per phase
  always_comb begin
    w_next      = r_state;
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    w_alu_op    = 2'b00;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_ir_write  = 1'b1;
        alu_src_b   = 2'b10;
        result_src  = 2'b10;
        w_pc_update = 1'b1;
        w_next      = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_JAL:       w_next = S_JAL;
          OP_BEQ:       w_next = S_BEQ;
          default: begin
            illegal    = 1'b1;
            instr_done = 1'b1;
            w_next     = TRAP_ON_ILLEGAL ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        if (op == OP_SW) begin
          w_next = S_MEMWRITE;
        end else begin
          w_next = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        w_next  = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = 2'b01;
        w_reg_write = 1'b1;
        instr_done  = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        w_mem_write = 1'b1;
        instr_done  = 1'b1;
        w_next      = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        w_alu_op  = 2'b10;
        w_next    = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        w_alu_op  = 2'b10;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        instr_done  = 1'b1;
        w_next      = S_FETCH;
      end
      S_JAL: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b10;
        w_pc_update = 1'b1;
        w_next      = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a  = 2'b10;
        w_alu_op   = 2'b01;
        w_branch   = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // Immediate format depends only on the opcode; HALT silences it
  always_comb begin
    imm_src = 2'b00;
    if (r_state == S_HALT) begin
      imm_src = 2'b00;
    end else begin
      case (op)
        OP_SW:   imm_src = 2'b01;
        OP_BEQ:  imm_src = 2'b10;
        OP_JAL:  imm_src = 2'b11;
        default: imm_src = 2'b00;
      endcase
    end
  end

  // ALU function decode; subtract only for R-type with funct7b5 set
  always_comb begin
    alu_control = 3'b000;
    case (w_alu_op)
      2'b00: alu_control = 3'b000;
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_control = ({op[5], funct7b5} == 2'b11) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  // Write enables are held off while reset is asserted, even mid-instruction
  assign pc_write  = rst_n & (w_pc_update | (w_branch & zero));
  assign ir_write  = rst_n & w_ir_write;
  assign reg_write = rst_n & w_reg_write;
  assign mem_write = rst_n & w_mem_write;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected control vectors
// come from an instruction-level model; a negedge monitor pops and compares.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;

  logic       pc_write, adr_src, mem_write, ir_write, reg_write, instr_done, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic       t_pc_write, t_adr_src, t_mem_write, t_ir_write, t_reg_write, t_instr_done, t_illegal;
  logic [1:0] t_result_src, t_alu_src_a, t_alu_src_b, t_imm_src;
  logic [2:0] t_alu_control;

  int errors = 0;
  int checks = 0;
  logic [17:0] exp_q[$];
  logic [17:0] mon_exp;

  always #5 clk = ~clk;

  multicycle_controller #(.TRAP_ON_ILLEGAL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .reg_write(reg_write), .imm_src(imm_src), .alu_control(alu_control),
    .instr_done(instr_done), .illegal(illegal));

  multicycle_controller #(.TRAP_ON_ILLEGAL(1'b1)) dut_trap (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .pc_write(t_pc_write), .adr_src(t_adr_src), .mem_write(t_mem_write), .ir_write(t_ir_write),
    .result_src(t_result_src), .alu_src_a(t_alu_src_a), .alu_src_b(t_alu_src_b),
    .reg_write(t_reg_write), .imm_src(t_imm_src), .alu_control(t_alu_control),
    .instr_done(t_instr_done), .illegal(t_illegal));

  wire [17:0] v0 = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
                    reg_write, imm_src, alu_control, instr_done, illegal};
  wire [17:0] v1 = {t_pc_write, t_adr_src, t_mem_write, t_ir_write, t_result_src, t_alu_src_a,
                    t_alu_src_b, t_reg_write, t_imm_src, t_alu_control, t_instr_done, t_illegal};

  // Instruction classes: 0 lw, 1 sw, 2 R, 3 I, 4 jal, 5 beq, 6 illegal
  function automatic int cls_of(input logic [6:0] o);
    case (o)
      7'b0000011: return 0;
      7'b0100011: return 1;
      7'b0110011: return 2;
      7'b0010011: return 3;
      7'b1101111: return 4;
      7'b1100011: return 5;
      default:    return 6;
    endcase
  endfunction

  function automatic int n_cycles(input int c);
    case (c)
      0: return 5;
      5: return 3;
      6: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [1:0] imm_of(input int c);
    case (c)
      1: return 2'b01;
      4: return 2'b11;
      5: return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Arithmetic operation an R/I instruction asks for: add, sub, slt, or, and
  function automatic logic [2:0] alu_of(input int c, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0: return (c == 2 && f7) ? 3'b001 : 3'b000;
      3'd2: return 3'b101;
      3'd6: return 3'b011;
      3'd7: return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [17:0] mk(input logic pcw, input logic adr, input logic mw, input logic irw,
                                     input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
                                     input logic rw, input logic [1:0] imm, input logic [2:0] alu,
                                     input logic done, input logic ill);
    return {pcw, adr, mw, irw, rs, sa, sb, rw, imm, alu, done, ill};
  endfunction

  // Expected control vector for cycle k of an instruction
  function automatic logic [17:0] expect_cycle(input logic [6:0] o, input logic [2:0] f3,
                                               input logic f7, input logic z, input int k);
    int c = cls_of(o);
    logic [1:0] im = imm_of(c);
    logic [17:0] wb = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, im, 3'b000, 1'b1, 1'b0);
    logic [17:0] ma = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0, im, 3'b000, 1'b0, 1'b0);
    if (k == 0) return mk(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 1'b0, im, 3'b000, 1'b0, 1'b0);
    if (k == 1) return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 1'b0, im, 3'b000,
                          c == 6, c == 6);
    case (c)
      0: begin
        if (k == 2) return ma;
        if (k == 3) return mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, im, 3'b000, 1'b0, 1'b0);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, im, 3'b000, 1'b1, 1'b0);
      end
      1: begin
        if (k == 2) return ma;
        return mk(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, im, 3'b000, 1'b1, 1'b0);
      end
      2, 3: begin
        if (k == 2) return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, (c == 3) ? 2'b01 : 2'b00, 1'b0,
                              im, alu_of(c, f3, f7), 1'b0, 1'b0);
        return wb;
      end
      4: begin
        if (k == 2) return mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0, im, 3'b000, 1'b0, 1'b0);
        return wb;
      end
      default: return mk(z, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, im, 3'b001, 1'b1, 1'b0);
    endcase
  endfunction

  task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the DUT against the oldest queued expectation each cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      chk("scoreboard", v0, mon_exp);
    end
  end

  // Drives one instruction from FETCH; entry and exit just after a rising edge
  task automatic run_instr(input logic [6:0] i_op, input logic [2:0] f3, input logic f7,
                           input int zm, input int ncyc, input bit chk_halt);
    int n = (ncyc > 0) ? ncyc : n_cycles(cls_of(i_op));
    op = i_op; funct3 = f3; funct7b5 = f7;
    for (int k = 0; k < n; k++) begin
      zero = (zm == 2) ? 1'($urandom_range(0, 1)) : 1'(zm);
      exp_q.push_back(expect_cycle(i_op, f3, f7, zero, k));
      if (chk_halt) begin
        #3;
        chk("halt_quiet", v1, 18'd0);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  logic [6:0] legal_ops [6];
  logic [6:0] bad_ops [4];
  logic [6:0] r_op;

  initial begin
    legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};
    bad_ops   = '{7'b1111111, 7'b0110111, 7'b0000000, 7'b0010111};
    rst_n = 1'b0; op = 7'b0000011; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
    #3;
    chk("reset_vec", v0, mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_instr(7'b0000011, 3'd2, 1'b0, 2, 0, 1'b0);
    run_instr(7'b0110011, 3'd0, 1'b1, 2, 0, 1'b0);
    run_instr(7'b0010011, 3'd0, 1'b1, 2, 0, 1'b0);
    run_instr(7'b1100011, 3'd0, 1'b0, 1, 0, 1'b0);
    run_instr(7'b1100011, 3'd0, 1'b0, 0, 0, 1'b0);
    run_instr(7'b1101111, 3'd0, 1'b0, 2, 0, 1'b0);
    run_instr(7'b1111111, 3'd0, 1'b0, 2, 0, 1'b0);
    run_instr(7'b0100011, 3'd2, 1'b0, 2, 0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      int s = $urandom_range(0, 6);
      r_op = (s == 6) ? bad_ops[$urandom_range(0, 3)] : legal_ops[s];
      run_instr(r_op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2, 0, 1'b0);
    end

    // Reset asserted while sw sits in MEMWRITE
    run_instr(7'b0100011, 3'd2, 1'b0, 2, 3, 1'b0);
    checks++;
    if (mem_write !== 1'b1) begin
      errors++;
      $display("FAIL memwrite_before_reset: got %b expected 1", mem_write);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_vec", v0, mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 1'b0, 2'b01, 3'b000, 1'b0, 1'b0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("post_reset_fetch", {13'd0, ir_write, pc_write, alu_control}, {13'd0, 1'b1, 1'b1, 3'b000});
    run_instr(7'b0000011, 3'd0, 1'b0, 2, 0, 1'b0);

    // Trapping variant halts after an illegal op; the non-trapping one continues
    do_reset();
    op = 7'b1111111; zero = 1'b0;
    exp_q.push_back(expect_cycle(op, 3'd0, 1'b0, 1'b0, 0));
    #3 chk("trap_fetch", v1, expect_cycle(op, 3'd0, 1'b0, 1'b0, 0));
    @(posedge clk); #1;
    exp_q.push_back(expect_cycle(op, 3'd0, 1'b0, 1'b0, 1));
    #3 chk("trap_decode", v1, mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 1'b0, 2'b00, 3'b000, 1'b1, 1'b1));
    @(posedge clk); #1;
    run_instr(7'b0100011, 3'd2, 1'b0, 2, 0, 1'b1);
    run_instr(7'b1101111, 3'd0, 1'b0, 2, 0, 1'b1);
    do_reset();
    #1;
    chk("trap_release", {16'd0, t_ir_write, t_pc_write}, {16'd0, 1'b1, 1'b1});

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multicycle RV32 core. It sequences the shared ALU, memory port, instruction register, PC and register file across the instruction phases: fetch, decode, address, execute, memory and writeback. It also contains the ALU function decode (ALUOp plus funct fields to ALUControl) in the team's encoding. It sits beside the datapath, takes instruction fields from the IR and `zero` from the ALU, and drives every datapath select and write enable.

## Interface
- TRAP_ON_ILLEGAL, 0, 0: illegal opcode returns to FETCH; 1: illegal opcode parks in HALT until reset
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- op  in  7  instr[6:0] from IR
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU result == 0
- pc_write  out  1  PC load enable
- adr_src  out  1  0 = PC, 1 = ALU result register for memory address
- mem_write  out  1  data memory write enable
- ir_write  out  1  IR and OldPC load enable
- result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult
- alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1
- alu_src_b  out  2  00 rs2, 01 ImmExt, 10 constant 4
- reg_write  out  1  register file write enable
- imm_src  out  2  00 I, 01 S, 10 B, 11 J
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- instr_done  out  1  high in the last cycle of each instruction
- illegal  out  1  high in DECODE when op is unsupported

## Operation
- Supported ops: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, jal 1101111, beq 1100011.
- Moore state register. Outputs not listed for a state are 0.
- FETCH: ir_write=1, alu_src_b=10, result_src=10, pc_update=1, ALUOp=00. Next state DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, ALUOp=00.
  - Next state is MEMADR for lw/sw, EXECR for R, EXECI for I, JAL for jal, BEQ for beq.
  - Any other op: illegal=1 and instr_done=1. Next state FETCH, or HALT if TRAP_ON_ILLEGAL=1.
- MEMADR: alu_src_a=10, alu_src_b=01, ALUOp=00. Next state MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: adr_src=1. Next state MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_done=1. Next state FETCH.
- MEMWRITE: adr_src=1, mem_write=1, instr_done=1. Next state FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, ALUOp=10. Next state ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, ALUOp=10. Next state ALUWB.
- ALUWB: reg_write=1, instr_done=1. Next state FETCH.
- JAL: alu_src_a=01, alu_src_b=10, pc_update=1. Next state ALUWB.
- BEQ: alu_src_a=10, ALUOp=01, branch=1, instr_done=1. Next state FETCH.
- HALT: all outputs 0, no exit except reset.
- pc_write = pc_update | (branch & zero).
- imm_src is decoded from op alone: lw/I 00, sw 01, beq 10, jal 11, other 00.
- alu_control decode:
  - ALUOp 00 → 000; ALUOp 01 → 001.
  - ALUOp 10, by funct3: 000 → 001 if {op[5],funct7b5}==11, else 000; 010 → 101; 110 → 011; 111 → 010; other → 000.

## Timing
- op, funct3 and funct7b5 are valid from DECODE onward; the IR loads at the end of FETCH. imm_src and alu_control are combinational from the current state and fields.
- Cycles per instruction, FETCH through final state: lw 5, sw 4, R 4, I 4, jal 4, beq 3, illegal 2.
- instr_done goes high exactly once per instruction. The next cycle is always FETCH, except under HALT.
- Reset, including mid-instruction:
  - rst_n low forces state to FETCH immediately.
  - While rst_n is low, pc_write, ir_write, reg_write and mem_write are forced to 0. All other outputs take their FETCH values.
  - The first rising edge after release performs a full FETCH.
- zero is sampled only in BEQ. Its value in any other state has no effect.

## Test plan
- Reset while in MEMWRITE with mem_write=1 → mem_write drops to 0 asynchronously. After release: ir_write=1, pc_write=1, alu_control=000.
- lw (op=0000011) → state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB. reg_write=1 and result_src=01 only in cycle 5. instr_done pulses once.
- R-type sub (funct3=000, funct7b5=1) → alu_control=001 in EXECR. addi with funct7b5=1 (op[5]=0) → alu_control=000 in EXECI.
- beq with zero=1 → pc_write=1 in cycle 3. With zero=0 → pc_write=0. Both cases return to FETCH after 3 cycles.
- jal → pc_write=1 in JAL with alu_src_a=01, alu_src_b=10. Next cycle ALUWB has reg_write=1, result_src=00.
- op=1111111 → illegal=1 in DECODE.
  - TRAP_ON_ILLEGAL=0: FETCH follows.
  - TRAP_ON_ILLEGAL=1: all outputs stay 0 until rst_n is pulsed.
